// File: rtl/itype_decoder.sv
// itype_decoder: consumer side of the itype interface.
// Buffers retirement blocks in a DEPTH-entry FIFO, decodes the head itype
// into one-hot event flags and flags illegal codes with a sticky error.
// Optional: define ITYPE_DECODER_STATS_EN to build saturating pop counters.
module itype_decoder #(
    parameter int unsigned ITYPE_LEN   = 3,
    parameter int unsigned IADDR_LEN   = 64,
    parameter int unsigned IRETIRE_LEN = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [IADDR_LEN-1:0]   iaddr_i,
    input  logic [IRETIRE_LEN-1:0] iretire_i,
    input  logic                   ilastsize_i,
    output logic                   ready_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   exception_o,
    output logic                   interrupt_o,
    output logic                   eret_o,
    output logic                   nontaken_branch_o,
    output logic                   taken_branch_o,
    output logic                   updiscon_o,
    output logic [IADDR_LEN-1:0]   iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic                   ilastsize_o,
    output logic                   error_o,
    output logic [31:0]            taken_cnt_o,
    output logic [31:0]            nontaken_cnt_o,
    output logic [31:0]            exc_cnt_o
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          error_q, error_d;

    logic [ITYPE_LEN-1:0]   itype_mem_q   [DEPTH];
    logic [IADDR_LEN-1:0]   iaddr_mem_q   [DEPTH];
    logic [IRETIRE_LEN-1:0] iretire_mem_q [DEPTH];
    logic                   ilast_mem_q   [DEPTH];

    logic                 in_hs, in_nonzero, in_legal, push, pop;
    logic [ITYPE_LEN-1:0] head_itype;

    assign ready_o    = (count_q != FULL);
    assign valid_o    = (count_q != '0);
    assign error_o    = error_q;
    assign head_itype = itype_mem_q[rd_ptr_q];

    // Input classification, handshake and FIFO next-state.
    always_comb begin
        in_nonzero = (itype_i != '0);
        in_legal   = ((itype_i >= ITYPE_LEN'(1)) && (itype_i <= ITYPE_LEN'(5)))
                  || ((ITYPE_LEN == 3) && (itype_i == ITYPE_LEN'(6)));
        in_hs      = valid_i && ready_o;
        push       = in_hs && in_legal;
        pop        = valid_o && ready_i;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        error_d = error_q | (in_hs && in_nonzero && !in_legal);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Entry storage; contents are unobservable while count is 0, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            itype_mem_q[wr_ptr_q]   <= itype_i;
            iaddr_mem_q[wr_ptr_q]   <= iaddr_i;
            iretire_mem_q[wr_ptr_q] <= iretire_i;
            ilast_mem_q[wr_ptr_q]   <= ilastsize_i;
        end
    end

    // Head decode; everything forced to zero while the FIFO is empty.
    always_comb begin
        exception_o       = 1'b0;
        interrupt_o       = 1'b0;
        eret_o            = 1'b0;
        nontaken_branch_o = 1'b0;
        taken_branch_o    = 1'b0;
        updiscon_o        = 1'b0;
        iaddr_o           = '0;
        iretire_o         = '0;
        ilastsize_o       = 1'b0;
        if (valid_o) begin
            iaddr_o     = iaddr_mem_q[rd_ptr_q];
            iretire_o   = iretire_mem_q[rd_ptr_q];
            ilastsize_o = ilast_mem_q[rd_ptr_q];
            case (head_itype)
                ITYPE_LEN'(1): exception_o       = 1'b1;
                ITYPE_LEN'(2): interrupt_o       = 1'b1;
                ITYPE_LEN'(3): eret_o            = 1'b1;
                ITYPE_LEN'(4): nontaken_branch_o = 1'b1;
                ITYPE_LEN'(5): taken_branch_o    = 1'b1;
                ITYPE_LEN'(6): updiscon_o        = 1'b1;
                default:       ;
            endcase
        end
    end

`ifdef ITYPE_DECODER_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] nontaken_cnt_q, nontaken_cnt_d;
    logic [31:0] exc_cnt_q, exc_cnt_d;

    // Saturating per-pop event counters.
    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        nontaken_cnt_d = nontaken_cnt_q;
        exc_cnt_d      = exc_cnt_q;
        if (pop) begin
            if (taken_branch_o && (taken_cnt_q != '1))
                taken_cnt_d = taken_cnt_q + 32'd1;
            if (nontaken_branch_o && (nontaken_cnt_q != '1))
                nontaken_cnt_d = nontaken_cnt_q + 32'd1;
            if ((exception_o || interrupt_o) && (exc_cnt_q != '1))
                exc_cnt_d = exc_cnt_q + 32'd1;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taken_cnt_q    <= '0;
            nontaken_cnt_q <= '0;
            exc_cnt_q      <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nontaken_cnt_q <= nontaken_cnt_d;
            exc_cnt_q      <= exc_cnt_d;
        end
    end

    assign taken_cnt_o    = taken_cnt_q;
    assign nontaken_cnt_o = nontaken_cnt_q;
    assign exc_cnt_o      = exc_cnt_q;
`else
    assign taken_cnt_o    = '0;
    assign nontaken_cnt_o = '0;
    assign exc_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_itype_decoder.sv
// Testbench for itype_decoder: directed vector table, hand-written
// concurrent push/pop sequence, randomized run against a queue model,
// and a short check of the ITYPE_LEN=4 legality rule.
module tb_itype_decoder;

    localparam int unsigned DEPTH = 4;
`ifdef ITYPE_DECODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, valid_i, ilastsize_i, ready_i;
    logic [2:0]  itype_i;
    logic [63:0] iaddr_i;
    logic [31:0] iretire_i;
    logic        ready_o, valid_o, exc_o, intr_o, eret_o, nt_o, tk_o, upd_o;
    logic [63:0] iaddr_o;
    logic [31:0] iretire_o;
    logic        ilastsize_o, error_o;
    logic [31:0] tk_cnt, nt_cnt, ex_cnt;

    // second instance with 4-bit itype
    logic        v4, rdy4;
    logic [3:0]  it4;
    logic        ready4, valid4, exc4, intr4, eret4, nt4, tk4, upd4, ils4, err4;
    logic [63:0] iaddr4;
    logic [31:0] iret4, tkc4, ntc4, exc4c;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    itype_decoder #(.ITYPE_LEN(3), .IADDR_LEN(64), .IRETIRE_LEN(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .itype_i(itype_i),
        .iaddr_i(iaddr_i), .iretire_i(iretire_i), .ilastsize_i(ilastsize_i),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
        .exception_o(exc_o), .interrupt_o(intr_o), .eret_o(eret_o),
        .nontaken_branch_o(nt_o), .taken_branch_o(tk_o), .updiscon_o(upd_o),
        .iaddr_o(iaddr_o), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
        .error_o(error_o), .taken_cnt_o(tk_cnt), .nontaken_cnt_o(nt_cnt),
        .exc_cnt_o(ex_cnt)
    );

    itype_decoder #(.ITYPE_LEN(4), .IADDR_LEN(64), .IRETIRE_LEN(32), .DEPTH(DEPTH)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(v4), .itype_i(it4),
        .iaddr_i(64'h0000_0000_0000_0500), .iretire_i(32'd9), .ilastsize_i(1'b0),
        .ready_o(ready4), .valid_o(valid4), .ready_i(rdy4),
        .exception_o(exc4), .interrupt_o(intr4), .eret_o(eret4),
        .nontaken_branch_o(nt4), .taken_branch_o(tk4), .updiscon_o(upd4),
        .iaddr_o(iaddr4), .iretire_o(iret4), .ilastsize_o(ils4),
        .error_o(err4), .taken_cnt_o(tkc4), .nontaken_cnt_o(ntc4),
        .exc_cnt_o(exc4c)
    );

    wire [5:0] flags = {upd_o, tk_o, nt_o, eret_o, intr_o, exc_o};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, v;
        logic [2:0]  it;
        logic [63:0] addr;
        logic [31:0] ret;
        logic        rdy;
        logic        e_valid, e_ready;
        logic [5:0]  e_flags;
        logic [63:0] e_addr;
        logic [31:0] e_ret;
        logic        e_err;
        logic [31:0] e_tk, e_nt, e_ex;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [2:0] it, input logic [63:0] a,
                       input logic [31:0] rt, input logic rd, input logic ev, input logic er,
                       input logic [5:0] ef, input logic [63:0] ea, input logic [31:0] eret,
                       input logic ee, input logic [31:0] tk, input logic [31:0] nt,
                       input logic [31:0] ex);
        vec_t t;
        t = '{r, v, it, a, rt, rd, ev, er, ef, ea, eret, ee, tk, nt, ex};
        tbl.push_back(t);
    endtask

    // ---------------- queue reference model ----------------
    typedef struct {
        logic [2:0]  it;
        logic [63:0] addr;
        logic [31:0] ret;
        logic        ls;
    } ent_t;

    ent_t        mq[$];
    logic        m_err;
    logic [31:0] m_tk, m_nt, m_ex;

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Apply current inputs for one edge, advance model, compare everything.
    task automatic model_cycle(input string tag);
        ent_t     h, e;
        int       sz;
        logic [5:0] ef;
        sz = mq.size();
        step();
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
            m_tk = 0; m_nt = 0; m_ex = 0;
        end else begin
            if (sz != 0 && ready_i) begin
                h = mq.pop_front();
                if (h.it == 3'd5) m_tk = sat_inc(m_tk);
                if (h.it == 3'd4) m_nt = sat_inc(m_nt);
                if (h.it == 3'd1 || h.it == 3'd2) m_ex = sat_inc(m_ex);
            end
            if (valid_i && sz != DEPTH) begin
                if (itype_i >= 3'd1 && itype_i <= 3'd6) begin
                    e.it = itype_i; e.addr = iaddr_i; e.ret = iretire_i; e.ls = ilastsize_i;
                    mq.push_back(e);
                end else if (itype_i == 3'd7) begin
                    m_err = 1'b1;
                end
            end
        end
        chk({tag, " valid"}, valid_o, mq.size() != 0);
        chk({tag, " ready"}, ready_o, mq.size() != DEPTH);
        chk({tag, " error"}, error_o, m_err);
        if (mq.size() != 0) begin
            ef = 6'd1 << (mq[0].it - 3'd1);
            chk({tag, " flags"}, flags, ef);
            chk({tag, " iaddr"}, iaddr_o, mq[0].addr);
            chk({tag, " iretire"}, iretire_o, mq[0].ret);
            chk({tag, " ilastsize"}, ilastsize_o, mq[0].ls);
        end else begin
            chk({tag, " flags"}, flags, 0);
            chk({tag, " iaddr"}, iaddr_o, 0);
            chk({tag, " iretire"}, iretire_o, 0);
            chk({tag, " ilastsize"}, ilastsize_o, 0);
        end
        chk({tag, " taken_cnt"}, tk_cnt, STATS ? m_tk : 32'd0);
        chk({tag, " nontaken_cnt"}, nt_cnt, STATS ? m_nt : 32'd0);
        chk({tag, " exc_cnt"}, ex_cnt, STATS ? m_ex : 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; itype_i = '0; iaddr_i = '0; iretire_i = '0;
        ilastsize_i = 1'b1; ready_i = 1'b0;
        v4 = 1'b0; it4 = '0; rdy4 = 1'b1;
        m_err = 1'b0; m_tk = 0; m_nt = 0; m_ex = 0;

        // reset
        add(1,0,0,64'h0,0,0,            0,1,6'h00,64'h0,0,0,            0,0,0);
        add(1,0,0,64'h0,0,0,            0,1,6'h00,64'h0,0,0,            0,0,0);
        add(0,0,0,64'h0,0,1,            0,1,6'h00,64'h0,0,0,            0,0,0);
        // single push, one-cycle latency, then popped
        add(0,1,5,64'h8000_0010,3,1,    1,1,6'h10,64'h8000_0010,3,0,    0,0,0);
        add(0,0,0,64'h0,0,1,            0,1,6'h00,64'h0,0,0,            1,0,0);
        // fill under backpressure
        add(0,1,1,64'h100,1,0,          1,1,6'h01,64'h100,1,0,          1,0,0);
        add(0,1,2,64'h104,2,0,          1,1,6'h01,64'h100,1,0,          1,0,0);
        add(0,1,3,64'h108,3,0,          1,1,6'h01,64'h100,1,0,          1,0,0);
        add(0,1,4,64'h10c,4,0,          1,0,6'h01,64'h100,1,0,          1,0,0);
        add(0,1,5,64'h110,5,0,          1,0,6'h01,64'h100,1,0,          1,0,0);
        // drain in order
        add(0,0,0,64'h0,0,1,            1,1,6'h02,64'h104,2,0,          1,0,1);
        add(0,0,0,64'h0,0,1,            1,1,6'h04,64'h108,3,0,          1,0,2);
        add(0,0,0,64'h0,0,1,            1,1,6'h08,64'h10c,4,0,          1,0,2);
        add(0,0,0,64'h0,0,1,            0,1,6'h00,64'h0,0,0,            1,1,2);
        // zero and illegal codes, then updiscon
        add(0,1,0,64'h200,0,1,          0,1,6'h00,64'h0,0,0,            1,1,2);
        add(0,1,7,64'h204,0,1,          0,1,6'h00,64'h0,0,1,            1,1,2);
        add(0,1,6,64'h208,6,1,          1,1,6'h20,64'h208,6,1,          1,1,2);
        add(0,0,0,64'h0,0,1,            0,1,6'h00,64'h0,0,1,            1,1,2);
        // reset mid-stream with 3 queued
        add(0,1,1,64'h300,1,0,          1,1,6'h01,64'h300,1,1,          1,1,2);
        add(0,1,2,64'h304,2,0,          1,1,6'h01,64'h300,1,1,          1,1,2);
        add(0,1,3,64'h308,3,0,          1,1,6'h01,64'h300,1,1,          1,1,2);
        add(1,0,0,64'h0,0,0,            0,1,6'h00,64'h0,0,0,            0,0,0);
        add(0,0,0,64'h0,0,1,            0,1,6'h00,64'h0,0,0,            0,0,0);
        add(0,0,0,64'h0,0,1,            0,1,6'h00,64'h0,0,0,            0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; valid_i = tbl[i].v; itype_i = tbl[i].it;
            iaddr_i = tbl[i].addr; iretire_i = tbl[i].ret; ready_i = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d valid", i), valid_o, tbl[i].e_valid);
            chk($sformatf("vec%0d ready", i), ready_o, tbl[i].e_ready);
            chk($sformatf("vec%0d flags", i), flags, tbl[i].e_flags);
            chk($sformatf("vec%0d iaddr", i), iaddr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d iretire", i), iretire_o, tbl[i].e_ret);
            chk($sformatf("vec%0d error", i), error_o, tbl[i].e_err);
            chk($sformatf("vec%0d taken_cnt", i), tk_cnt, STATS ? tbl[i].e_tk : 32'd0);
            chk($sformatf("vec%0d nontaken_cnt", i), nt_cnt, STATS ? tbl[i].e_nt : 32'd0);
            chk($sformatf("vec%0d exc_cnt", i), ex_cnt, STATS ? tbl[i].e_ex : 32'd0);
        end

        // concurrent push/pop with two entries held, across pointer wrap
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        model_cycle("cc_rst");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; itype_i = 3'(i + 1); iaddr_i = 64'h400 + 64'(i * 4);
            iretire_i = 32'(i); ilastsize_i = 1'(i);
            model_cycle($sformatf("cc_fill%0d", i));
        end
        ready_i = 1'b1;
        for (int i = 2; i < 10; i++) begin
            valid_i = 1'b1; itype_i = 3'((i % 6) + 1); iaddr_i = 64'h400 + 64'(i * 4);
            iretire_i = 32'(i); ilastsize_i = 1'(i);
            model_cycle($sformatf("cc%0d", i));
            chk($sformatf("cc%0d valid_held", i), valid_o, 1'b1);
        end

        // randomized run
        valid_i = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rst         = ($urandom_range(0, 79) == 0);
            valid_i     = ($urandom_range(0, 3) != 0);
            itype_i     = 3'($urandom_range(0, 7));
            if (itype_i == 3'd7 && $urandom_range(0, 7) != 0) itype_i = 3'd5;
            iaddr_i     = {$urandom, $urandom};
            iretire_i   = $urandom;
            ilastsize_i = 1'($urandom);
            ready_i     = ($urandom_range(0, 2) != 0);
            model_cycle($sformatf("rnd%0d", i));
        end

        // ITYPE_LEN=4: 6 is illegal
        rst = 1'b1; valid_i = 1'b0; v4 = 1'b0;
        step();
        rst = 1'b0; v4 = 1'b1; it4 = 4'd5; rdy4 = 1'b1;
        step();
        chk("w4 valid", valid4, 1'b1);
        chk("w4 taken", tk4, 1'b1);
        chk("w4 error_before", err4, 1'b0);
        it4 = 4'd6;
        step();
        chk("w4 error_after6", err4, 1'b1);
        chk("w4 six_discarded", valid4, 1'b0);
        v4 = 1'b0;
        step();
        chk("w4 error_sticky", err4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
